// File: rtl/life_row_scanner.sv
// Snapshots the Life cell grid on request and streams it out one row per valid/ready transfer.
// Optional live-cell population counter enabled by defining LIFE_SCAN_POPCOUNT_EN.
module life_row_scanner #(
    parameter int WIDTH  = 8,
    parameter int HEIGHT = 8,
    parameter int IW     = $clog2(HEIGHT),
    parameter int PW     = $clog2(WIDTH*HEIGHT+1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [WIDTH*HEIGHT-1:0] grid_state,
    input  logic                    start,
    output logic                    busy,
    output logic                    row_valid,
    input  logic                    row_ready,
    output logic [WIDTH-1:0]        row_data,
    output logic [IW-1:0]           row_index,
    output logic                    frame_last,
    output logic                    done
`ifdef LIFE_SCAN_POPCOUNT_EN
    ,
    output logic [PW-1:0]           population
`endif
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t                    state_q, state_d;
    logic [WIDTH*HEIGHT-1:0]   snap_q, snap_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [WIDTH-1:0]          row_data_q, row_data_d;
    logic                      row_valid_q, row_valid_d;
    logic                      busy_q, busy_d;
    logic                      frame_last_q, frame_last_d;
    logic                      done_q, done_d;
    logic                      xfer_s;
    logic                      last_s;
    logic [IW-1:0]             idx_inc_s;

    assign last_s    = (idx_q == IW'(HEIGHT-1));
    assign idx_inc_s = idx_q + {{(IW-1){1'b0}}, 1'b1};

    // Next-state and registered-output computation
    always_comb begin
        state_d      = state_q;
        snap_d       = snap_q;
        idx_d        = idx_q;
        row_data_d   = row_data_q;
        row_valid_d  = row_valid_q;
        busy_d       = busy_q;
        frame_last_d = frame_last_q;
        done_d       = 1'b0;
        xfer_s       = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d      = STREAM;
                    snap_d       = grid_state;
                    idx_d        = {IW{1'b0}};
                    row_data_d   = grid_state[WIDTH-1:0];
                    row_valid_d  = 1'b1;
                    busy_d       = 1'b1;
                    frame_last_d = (HEIGHT == 1);
                end else begin
                    state_d = IDLE;
                end
            end
            STREAM: begin
                xfer_s = row_valid_q & row_ready;
                if (xfer_s && last_s) begin
                    state_d      = DONE;
                    row_valid_d  = 1'b0;
                    frame_last_d = 1'b0;
                    done_d       = 1'b1;
                end else if (xfer_s) begin
                    idx_d        = idx_inc_s;
                    row_data_d   = snap_q[int'(idx_inc_s)*WIDTH +: WIDTH];
                    frame_last_d = (idx_inc_s == IW'(HEIGHT-1));
                end else begin
                    state_d = STREAM;
                end
            end
            DONE: begin
                state_d    = IDLE;
                busy_d     = 1'b0;
                idx_d      = {IW{1'b0}};
                row_data_d = {WIDTH{1'b0}};
            end
            default: begin
                state_d      = IDLE;
                idx_d        = {IW{1'b0}};
                row_data_d   = {WIDTH{1'b0}};
                row_valid_d  = 1'b0;
                busy_d       = 1'b0;
                frame_last_d = 1'b0;
            end
        endcase
    end

    // State, snapshot and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            snap_q       <= {(WIDTH*HEIGHT){1'b0}};
            idx_q        <= {IW{1'b0}};
            row_data_q   <= {WIDTH{1'b0}};
            row_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_last_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            snap_q       <= snap_d;
            idx_q        <= idx_d;
            row_data_q   <= row_data_d;
            row_valid_q  <= row_valid_d;
            busy_q       <= busy_d;
            frame_last_q <= frame_last_d;
            done_q       <= done_d;
        end
    end

    assign busy       = busy_q;
    assign row_valid  = row_valid_q;
    assign row_data   = row_data_q;
    assign row_index  = idx_q;
    assign frame_last = frame_last_q;
    assign done       = done_q;

`ifdef LIFE_SCAN_POPCOUNT_EN
    function automatic logic [PW-1:0] popcount(input logic [WIDTH-1:0] v);
        logic [PW-1:0] n;
        n = {PW{1'b0}};
        for (int i = 0; i < WIDTH; i++) begin
            n = n + PW'(v[i]);
        end
        return n;
    endfunction

    logic [PW-1:0] acc_q, acc_d;
    logic [PW-1:0] pop_q, pop_d;

    // Running sum of transferred rows; population latches the total, last row included
    always_comb begin
        acc_d = acc_q;
        pop_d = pop_q;
        if (state_q == IDLE && start) begin
            acc_d = {PW{1'b0}};
        end else if (xfer_s && last_s) begin
            pop_d = acc_q + popcount(row_data_q);
        end else if (xfer_s) begin
            acc_d = acc_q + popcount(row_data_q);
        end else begin
            acc_d = acc_q;
        end
    end

    // Population registers
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q <= {PW{1'b0}};
            pop_q <= {PW{1'b0}};
        end else begin
            acc_q <= acc_d;
            pop_q <= pop_d;
        end
    end

    assign population = pop_q;
`endif

endmodule

// File: tb/tb_life_row_scanner.sv
// Directed self-checking bench for life_row_scanner (8x8 grid), with population checks
// when LIFE_SCAN_POPCOUNT_EN is defined.
module tb_life_row_scanner;

    localparam int WIDTH  = 8;
    localparam int HEIGHT = 8;
    localparam logic [63:0] GLIDER = 64'h0000_0000_0E02_0400;
    localparam logic [63:0] ONES   = 64'hFFFF_FFFF_FFFF_FFFF;

    logic        clk = 1'b0;
    logic        rst;
    logic [63:0] grid_state;
    logic        start;
    logic        busy;
    logic        row_valid;
    logic        row_ready;
    logic [7:0]  row_data;
    logic [2:0]  row_index;
    logic        frame_last;
    logic        done;
`ifdef LIFE_SCAN_POPCOUNT_EN
    logic [6:0]  population;
`endif

    int checks   = 0;
    int failures = 0;

    life_row_scanner #(.WIDTH(WIDTH), .HEIGHT(HEIGHT)) dut (
        .clk        (clk),
        .rst        (rst),
        .grid_state (grid_state),
        .start      (start),
        .busy       (busy),
        .row_valid  (row_valid),
        .row_ready  (row_ready),
        .row_data   (row_data),
        .row_index  (row_index),
        .frame_last (frame_last),
        .done       (done)
`ifdef LIFE_SCAN_POPCOUNT_EN
        ,
        .population (population)
`endif
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_pop(input string tag, input int exp);
`ifdef LIFE_SCAN_POPCOUNT_EN
        check_eq(tag, 64'(population), 64'(exp));
`endif
    endtask

    // Captures exp_grid, then presents grid_after; optional stall and spurious start pulses.
    task automatic run_frame(input logic [63:0] exp_grid, input logic [63:0] grid_after,
                             input int stall_row, input int stall_n,
                             input bit poke_start, input int exp_pop);
        logic [7:0] exp_row;
        grid_state = exp_grid;
        start      = 1'b1;
        row_ready  = 1'b1;
        tick();
        start      = 1'b0;
        grid_state = grid_after;
        for (int r = 0; r < HEIGHT; r++) begin
            exp_row = exp_grid[r*8 +: 8];
            if (r == stall_row) begin
                row_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    check_eq("stall_data", 64'(row_data), 64'(exp_row));
                    check_eq("stall_index", 64'(row_index), 64'(r));
                    check_eq("stall_valid", 64'(row_valid), 64'd1);
                    tick();
                end
                row_ready = 1'b1;
            end
            if (poke_start && r == 3) start = 1'b1;
            check_eq("row_data", 64'(row_data), 64'(exp_row));
            check_eq("row_index", 64'(row_index), 64'(r));
            check_eq("row_valid", 64'(row_valid), 64'd1);
            check_eq("frame_last", 64'(frame_last), 64'(r == HEIGHT-1));
            check_eq("done_early", 64'(done), 64'd0);
            check_eq("busy_stream", 64'(busy), 64'd1);
            tick();
            start = 1'b0;
        end
        if (poke_start) start = 1'b1;
        check_eq("done_pulse", 64'(done), 64'd1);
        check_eq("done_valid", 64'(row_valid), 64'd0);
        check_eq("done_busy", 64'(busy), 64'd1);
        check_pop("population", exp_pop);
        tick();
        start = 1'b0;
        check_eq("post_done", 64'(done), 64'd0);
        check_eq("post_busy", 64'(busy), 64'd0);
        check_eq("post_valid", 64'(row_valid), 64'd0);
        check_eq("post_index", 64'(row_index), 64'd0);
        check_pop("pop_hold", exp_pop);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        row_ready  = 1'b0;
        grid_state = 64'h0;
        tick();
        tick();
        rst = 1'b0;

        // idle after reset: everything low
        for (int i = 0; i < 10; i++) begin
            check_eq("reset_idle", {busy, row_valid, row_data, row_index, frame_last, done}, 64'd0);
            check_pop("reset_pop", 0);
            tick();
        end

        // glider, no stall
        run_frame(GLIDER, GLIDER, -1, 0, 1'b0, 5);
        // backpressure on row 2 for three cycles
        run_frame(GLIDER, GLIDER, 2, 3, 1'b0, 5);
        // grid changes after capture; start poked in STREAM and DONE
        run_frame(GLIDER, ONES, -1, 0, 1'b1, 5);
        // IDLE cycle directly after DONE captures a new frame
        run_frame(ONES, 64'h0, -1, 0, 1'b0, 64);

        // reset mid-frame
        grid_state = GLIDER;
        start      = 1'b1;
        row_ready  = 1'b1;
        tick();
        start = 1'b0;
        for (int r = 0; r < 4; r++) tick();
        check_eq("pre_rst_index", 64'(row_index), 64'd4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst_valid", 64'(row_valid), 64'd0);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_pop("rst_pop", 0);
        for (int i = 0; i < 6; i++) begin
            check_eq("rst_no_done", {busy, row_valid, done}, 64'd0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
